// File: rtl/fifo_sync_pkg.sv
// Shared helpers for the synchronous FIFO: address-width function and read-mode constants.
package fifo_sync_pkg;

  localparam int FWFT_STD  = 0;
  localparam int FWFT_FALL = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with registered read; no reset on storage so it maps onto block RAM.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  CLK,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: pointers, occupancy, registered flags, sticky errors and the
// standard / first-word-fall-through output stage around a block-RAM store.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2,
  parameter int FWFT         = 0
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    CLEAR,
  input  logic                    WR_EN,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  input  logic                    RD_EN,
  output logic [DATA_WIDTH-1:0]   RD_DATA,
  output logic                    RD_VALID,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic                    ALMOST_FULL,
  output logic                    ALMOST_EMPTY,
  output logic [clog2(DEPTH):0]   COUNT,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);
  localparam bit LEGAL = (DEPTH >= 4) && ((DEPTH & (DEPTH - 1)) == 0) &&
                         (AEMPTY_LEVEL < AFULL_LEVEL) && (AFULL_LEVEL <= DEPTH) &&
                         ((FWFT == FWFT_STD) || (FWFT == FWFT_FALL));

  if (!LEGAL) begin : g_bad_params
    $fatal(1, "fifo_sync: illegal DEPTH/AFULL_LEVEL/AEMPTY_LEVEL/FWFT parameters");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         count_nxt;
  logic                  wr_acc, rd_acc;
  logic                  ram_rd_en;
  logic [AW-1:0]         ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_q;

  always_comb begin
    wr_acc     = WR_EN & ~FULL & ~CLEAR;
    rd_acc     = RD_EN & ~EMPTY & ~CLEAR;
    wr_ptr_nxt = CLEAR ? '0 : wr_ptr + AW'(wr_acc);
    rd_ptr_nxt = CLEAR ? '0 : rd_ptr + AW'(rd_acc);
    count_nxt  = CLEAR ? '0 : COUNT + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      COUNT        <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      COUNT        <= count_nxt;
      FULL         <= (count_nxt == DEPTH_C);
      EMPTY        <= (count_nxt == '0);
      ALMOST_FULL  <= (count_nxt >= AFULL_C);
      ALMOST_EMPTY <= (count_nxt <= AEMPTY_C);
      if (CLEAR) begin
        OVERFLOW  <= 1'b0;
        UNDERFLOW <= 1'b0;
      end else begin
        if (WR_EN && FULL)  OVERFLOW  <= 1'b1;
        if (RD_EN && EMPTY) UNDERFLOW <= 1'b1;
      end
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (WR_DATA),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_q)
  );

  if (FWFT == FWFT_FALL) begin : g_fwft
    // RAM prefetches the next head every cycle; a write landing on that head
    // in the same cycle would be missed by the read, so it is forwarded.
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) byp_q <= 1'b0;
      else          byp_q <= wr_acc && (wr_ptr == rd_ptr_nxt);
    end

    always_ff @(posedge CLK) byp_data <= WR_DATA;

    assign ram_rd_en   = 1'b1;
    assign ram_rd_addr = rd_ptr_nxt;
    assign RD_DATA     = byp_q ? byp_data : ram_q;
    assign RD_VALID    = ~EMPTY;
  end else begin : g_std
    logic rd_valid_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) rd_valid_q <= 1'b0;
      else          rd_valid_q <= rd_acc;
    end

    assign ram_rd_en   = rd_acc;
    assign ram_rd_addr = rd_ptr;
    assign RD_DATA     = ram_q;
    assign RD_VALID    = rd_valid_q;
  end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word in bits.
REQ-002 Parameter DEPTH, default 16: number of entries; power of two, at least 4.
REQ-003 Parameter AFULL_LEVEL, default 14: COUNT at or above which ALMOST_FULL asserts.
REQ-004 Parameter AEMPTY_LEVEL, default 2: COUNT at or below which ALMOST_EMPTY asserts.
REQ-005 Parameter FWFT, default 0: 0 selects standard read mode; 1 selects first-word-fall-through mode.
REQ-006 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-007 RESET_N  input  1  asynchronous, active-low reset.
REQ-008 CLEAR  input  1  synchronous flush of contents and sticky errors.
REQ-009 WR_EN  input  1  write request.
REQ-010 WR_DATA  input  DATA_WIDTH  write word.
REQ-011 RD_EN  input  1  read request (pop).
REQ-012 RD_DATA  output  DATA_WIDTH  read word.
REQ-013 RD_VALID  output  1  RD_DATA is valid.
REQ-014 FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  output  1 each  status flags.
REQ-015 COUNT  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 OVERFLOW, UNDERFLOW  output  1 each  sticky error flags.

Function
REQ-017 A write SHALL be accepted iff WR_EN=1 and FULL=0; a read SHALL be accepted iff RD_EN=1 and EMPTY=0.
REQ-018 A rejected write SHALL set OVERFLOW; a rejected read SHALL set UNDERFLOW; both SHALL remain set until CLEAR or reset.
REQ-019 Simultaneous accepted read and write SHALL leave COUNT unchanged.
REQ-020 When FULL, a simultaneous read and write SHALL accept the read, reject the write, and set OVERFLOW.
REQ-021 When EMPTY, a simultaneous read and write SHALL accept the write, reject the read, and set UNDERFLOW.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-023 All flags SHALL be registered and reflect COUNT after the same clock edge:
- FULL = (COUNT==DEPTH)
- EMPTY = (COUNT==0)
- ALMOST_FULL = (COUNT>=AFULL_LEVEL)
- ALMOST_EMPTY = (COUNT<=AEMPTY_LEVEL)
REQ-024 FWFT=0: RD_DATA SHALL present the popped word one cycle after the accepted read, with RD_VALID pulsing high for exactly that cycle; RD_DATA SHALL hold its value otherwise.
REQ-025 FWFT=1: RD_VALID SHALL equal !EMPTY and RD_DATA SHALL show the head word; an accepted read advances to the next word on the following cycle.
REQ-026 FWFT=1: a word written into an empty FIFO SHALL appear on RD_DATA with RD_VALID=1 one cycle after the write.
REQ-027 CLEAR SHALL take priority over WR_EN and RD_EN in the same cycle:
- pointers and COUNT return to 0
- OVERFLOW and UNDERFLOW are cleared
- RD_VALID is driven to 0
REQ-028 Storage contents SHALL NOT be reset or cleared.

Reset
REQ-029 RESET_N low SHALL immediately force the following; RD_DATA is not reset:
- COUNT=0, pointers=0
- EMPTY=1, ALMOST_EMPTY=1
- FULL=0, ALMOST_FULL=0
- RD_VALID=0
- OVERFLOW=0, UNDERFLOW=0
REQ-030 Reset asserted mid-operation SHALL discard all in-flight reads and writes.
REQ-031 Reset deassertion SHALL take effect on the next rising CLK edge; WR_EN/RD_EN in that cycle SHALL be honoured.

Structure
REQ-032 A shared include file fifo_defs.vh SHALL hold the clog2 function and the FWFT mode constants.
REQ-033 Storage SHALL be a sub-module fifo_ram: a DEPTH x DATA_WIDTH simple dual-port RAM with registered read, inferable as Altera block RAM.
REQ-034 fifo_sync SHALL contain the pointer, count and flag logic and the FWFT output stage.
REQ-035 Parameter legality (DEPTH power of two, AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH) SHALL be checked at elaboration with $display and $finish.

Verification
REQ-036 Fill: DEPTH=16, write 0x00..0x0F:
- FULL=1, COUNT=16, ALMOST_FULL asserted when COUNT reached 14
- a 17th write sets OVERFLOW and leaves the contents unchanged
REQ-037 Drain in FWFT=0: 16 reads return 0x00..0x0F in order, each one cycle after its RD_EN; then EMPTY=1 and a further read sets UNDERFLOW.
REQ-038 Wrap: 40 cycles of continuous simultaneous read/write at COUNT=8 leave COUNT=8 and the data sequence intact across the pointer wrap.
REQ-039 FWFT=1: a single write of 0xA5 to an empty FIFO gives RD_VALID=1 and RD_DATA=0xA5 on the next cycle; popping it returns EMPTY=1.
REQ-040 Boundaries and reset:
- full plus simultaneous RD/WR: COUNT goes to 15 and OVERFLOW=1
- CLEAR at COUNT=9 with WR_EN=1: COUNT=0 and both errors cleared
- RESET_N low mid-burst: all outputs at reset values immediately
